imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: start  in  1  begin load; sampled only in IDLE.
REQ-004 SHALL have ports: start_addr  in  10  first word index in instruction memory.
REQ-005 SHALL have ports: word_count  in  11  number of words to load, 1..1024.
REQ-006 SHALL have ports: abort  in  1  cancel an in-progress load.
REQ-007 SHALL have ports: byte_valid  in  1  upstream byte present.
REQ-008 SHALL have ports: byte_data  in  8  upstream byte.
REQ-009 SHALL have ports: byte_ready  out  1  loader accepts a byte this cycle.
REQ-010 SHALL have ports: mem_we  out  1  instruction-memory write strobe.
REQ-011 SHALL have ports: mem_addr  out  10  word index being written.
REQ-012 SHALL have ports: mem_wdata  out  32  word being written.
REQ-013 SHALL have ports: busy  out  1  load in progress; the core SHALL hold PC and IF_ID_Write low while this is high.
REQ-014 SHALL have ports: done  out  1  one-cycle pulse on successful completion.
REQ-015 SHALL have ports: err  out  1  one-cycle pulse on rejected start or abort.
REQ-016 SHALL have ports: checksum  out  32  XOR of all words written in the last completed load.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, WRITE, DONE.
REQ-018 IDLE: start=1 with 1<=word_count<=1024 and start_addr+word_count<=1024 SHALL go to LOAD; latch base, count, and clear word index, byte index, and running checksum.
REQ-019 IDLE: start=1 with word_count=0, word_count>1024, or start_addr+word_count>1024 SHALL pulse err the next cycle and stay in IDLE; no address wrap-around SHALL be permitted.
REQ-020 byte_ready SHALL be 1 only in LOAD; a byte is accepted when byte_valid&byte_ready.
REQ-021 Bytes SHALL pack little-endian: 1st accepted byte into [7:0], 2nd into [15:8], 3rd into [23:16], 4th into [31:24].
REQ-022 Acceptance of the 4th byte SHALL move LOAD->WRITE; in the following cycle mem_we=1, mem_addr=base+word index, mem_wdata=assembled word (latency 1 cycle, 5 cycles/word minimum).
REQ-023 mem_we SHALL be high for exactly one cycle per word and never outside WRITE.
REQ-024 WRITE SHALL XOR the word into the running checksum and increment the word index; if this was the last word, go to DONE, else return to LOAD with byte index 0.
REQ-025 DONE SHALL pulse done for one cycle, copy the running checksum to checksum, and go to IDLE.
REQ-026 busy SHALL be 1 in LOAD, WRITE, and DONE, and 0 in IDLE.
REQ-027 abort=1 in LOAD or WRITE SHALL have priority over all other events: no mem_we that cycle, discard the partial word, pulse err the next cycle, return to IDLE, and leave checksum unchanged.
REQ-028 byte_valid gaps SHALL stall assembly without loss; start asserted while busy SHALL be ignored.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE and set byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, checksum=0, with all counters at 0.
REQ-030 Reset mid-load SHALL abandon the load; words already written remain in memory, and no done or err pulse SHALL follow.

Structure
REQ-031 Package imem_loader_pkg SHALL hold the state enum, IMEM_DEPTH=1024, IMEM_ADDR_W=10, and WORD_W=32.
REQ-032 Byte packing (byte index counter plus shift/insert into a 32-bit register) SHALL be the sub-module word_assembler; the FSM, address/count, and checksum logic SHALL live in imem_loader.

Verification
REQ-033 start_addr=0, word_count=1, bytes 13,00,00,00 -> one mem_we with addr 0, wdata 0x00000013; done pulse; checksum=0x00000013; busy low afterwards.
REQ-034 start_addr=1022, word_count=2, words 0xDEADBEEF then 0x00000013 sent as bytes with random valid gaps -> writes at addr 1022 and 1023 in order; checksum=0xDEADBEFC.
REQ-035 start_addr=1020, word_count=5 -> err pulse, no byte_ready, no mem_we, state stays IDLE; repeat with word_count=0 -> same response.
REQ-036 abort asserted after 2 bytes of word 3 of a 4-word load -> no further mem_we, err pulse, checksum keeps its previous value, busy=0 the next cycle.
REQ-037 rst asserted in WRITE -> mem_we and busy drop without waiting for a clock edge; no done or err pulse; a new start then loads correctly.
REQ-038 word_count=1024, start_addr=0 -> exactly 1024 mem_we strobes at addr 0..1023, then a single done pulse.

Source files
------------

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Brief    : Shared types, sizes and range check for the instruction loader.
// Revision : 1.0
// ============================================================================
package imem_loader_pkg;

    localparam int IMEM_DEPTH  = 1024;
    localparam int IMEM_ADDR_W = 10;
    localparam int WORD_W      = 32;
    localparam int COUNT_W     = IMEM_ADDR_W + 1;
    localparam int SUM_W       = COUNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A load is legal only if it is non-empty and fits without wrapping.
    function automatic logic range_ok(
        input logic [IMEM_ADDR_W-1:0] addr,
        input logic [COUNT_W-1:0]     cnt
    );
        logic [SUM_W-1:0] w_end;
        w_end = {2'b00, addr} + {1'b0, cnt};
        return (cnt != '0) &&
               (cnt <= COUNT_W'(IMEM_DEPTH)) &&
               (w_end <= SUM_W'(IMEM_DEPTH));
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : word_assembler
// Brief    : Packs accepted bytes little-endian into a 32-bit word.
// Revision : 1.0
// ============================================================================
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);

    logic [1:0]        r_idx;
    logic [WORD_W-1:0] r_word;

    // Every byte lane is overwritten per word, so no clearing of the word is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (clear) begin
            r_idx  <= '0;
        end else if (accept) begin
            r_word[{r_idx, 3'b000} +: 8] <= byte_data;
            r_idx                        <= r_idx + 2'd1;
        end
    end

    assign word      = r_word;
    assign word_done = accept && (r_idx == 2'd3);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Streams bytes into instruction memory words with checksum.
// Revision : 1.0
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [IMEM_ADDR_W-1:0] start_addr,
    input  logic [COUNT_W-1:0]     word_count,
    input  logic                   abort,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   mem_we,
    output logic [IMEM_ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0]      mem_wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [WORD_W-1:0]      checksum
);

    state_t                 r_state;
    state_t                 w_next;
    logic [IMEM_ADDR_W-1:0] r_base;
    logic [COUNT_W-1:0]     r_count;
    logic [COUNT_W-1:0]     r_widx;
    logic [WORD_W-1:0]      r_running;
    logic [WORD_W-1:0]      r_checksum;
    logic                   r_err;

    logic                   w_in_idle;
    logic                   w_range_ok;
    logic                   w_start_ok;
    logic                   w_start_bad;
    logic                   w_abort;
    logic                   w_accept;
    logic                   w_word_done;
    logic                   w_last_word;
    logic                   w_commit;
    logic [WORD_W-1:0]      w_word;

    assign w_in_idle   = (r_state == ST_IDLE);
    assign w_range_ok  = range_ok(start_addr, word_count);
    assign w_start_ok  = w_in_idle && start && w_range_ok;
    assign w_start_bad = w_in_idle && start && !w_range_ok;
    assign w_abort     = abort && ((r_state == ST_LOAD) || (r_state == ST_WRITE));
    assign w_accept    = byte_valid && byte_ready;
    assign w_last_word = ((r_widx + COUNT_W'(1)) == r_count);
    assign w_commit    = (r_state == ST_WRITE) && !abort;

    word_assembler u_word_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_start_ok || w_abort),
        .accept    (w_accept),
        .byte_data (byte_data),
        .word      (w_word),
        .word_done (w_word_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort outranks byte completion and word commit in both active states.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (w_word_done) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (w_last_word) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_LOAD;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            ST_LOAD: begin
                busy       = 1'b1;
                byte_ready = !abort;
            end
            ST_WRITE: begin
                busy   = 1'b1;
                mem_we = !abort;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base    <= '0;
            r_count   <= '0;
            r_widx    <= '0;
            r_running <= '0;
        end else if (w_start_ok) begin
            r_base    <= start_addr;
            r_count   <= word_count;
            r_widx    <= '0;
            r_running <= '0;
        end else if (w_commit) begin
            r_running <= r_running ^ w_word;
            r_widx    <= r_widx + COUNT_W'(1);
        end
    end

    // The published checksum only moves on a completed load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_start_bad || w_abort;
            if (r_state == ST_DONE) begin
                r_checksum <= r_running;
            end
        end
    end

    assign mem_addr  = r_base + r_widx[IMEM_ADDR_W-1:0];
    assign mem_wdata = w_word;
    assign err       = r_err;
    assign checksum  = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Self-checking bench for imem_loader with write/checksum model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        start      = 1'b0;
    logic [9:0]  start_addr = '0;
    logic [10:0] word_count = '0;
    logic        abort      = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data  = '0;
    logic        byte_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] checksum;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .abort      (abort),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          we_cnt   = 0;
    wr_t         exp_q[$];
    wr_t         cmp_e;
    logic [31:0] load_ck  = '0;
    logic [31:0] exp_ck   = '0;
    logic        done_pend = 1'b0;
    logic [9:0]  next_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Model: expected writes in order, checksum published the cycle after done.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_ctl", {27'b0, byte_ready, mem_we, busy, done, err}, 32'h0);
            check("rst_addr", {22'b0, mem_addr}, 32'h0);
            check("rst_wdata", mem_wdata, 32'h0);
            check("rst_checksum", checksum, 32'h0);
            exp_ck    = '0;
            done_pend = 1'b0;
        end else begin
            if (done_pend) begin
                exp_ck    = load_ck;
                done_pend = 1'b0;
            end
            check("checksum", checksum, exp_ck);
            check("ready_implies_busy", {31'b0, byte_ready & ~busy}, 32'h0);
            check("we_exclusive", {31'b0, mem_we & (~busy | byte_ready)}, 32'h0);
            if (mem_we) begin
                we_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'h1, 32'h0);
                end else begin
                    cmp_e = exp_q.pop_front();
                    check("mem_addr", {22'b0, mem_addr}, {22'b0, cmp_e.addr});
                    check("mem_wdata", mem_wdata, cmp_e.data);
                end
            end
            if (done) begin
                done_cnt++;
                done_pend = 1'b1;
                check("done_all_written", exp_q.size(), 32'h0);
            end
            if (err) err_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        logic got;
        got = 1'b0;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            acc = byte_ready;
            tick();
            got = acc;
        end
        byte_valid = 1'b0;
        if (!got) check("byte_accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        wr_t e;
        e = {next_addr, w};
        exp_q.push_back(e);
        load_ck   = load_ck ^ w;
        next_addr = next_addr + 10'd1;
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic start_load(input logic [9:0] addr, input logic [10:0] cnt);
        start      = 1'b1;
        start_addr = addr;
        word_count = cnt;
        next_addr  = addr;
        load_ck    = '0;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_load(input int d0, input logic [31:0] exp_lit);
        for (int t = 0; t < 10 && done_cnt == d0; t++) tick();
        check("done_seen", done_cnt - d0, 32'h1);
        tick();
        tick();
        check("done_single_pulse", done_cnt - d0, 32'h1);
        check("checksum_literal", checksum, exp_lit);
        check("busy_after_load", {31'b0, busy}, 32'h0);
    endtask

    task automatic reject(input logic [9:0] addr, input logic [10:0] cnt);
        int e0;
        int w0;
        e0 = err_cnt;
        w0 = we_cnt;
        byte_valid = 1'b1;
        start      = 1'b1;
        start_addr = addr;
        word_count = cnt;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("reject_err", {31'b0, err}, 32'h1);
        check("reject_busy", {31'b0, busy}, 32'h0);
        check("reject_ready", {31'b0, byte_ready}, 32'h0);
        tick();
        @(negedge clk);
        check("reject_err_once", {31'b0, err}, 32'h0);
        check("reject_busy_idle", {31'b0, busy}, 32'h0);
        tick();
        byte_valid = 1'b0;
        check("reject_err_count", err_cnt - e0, 32'h1);
        check("reject_no_write", we_cnt - w0, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d0;
        int          e0;
        int          w0;
        logic [31:0] v;

        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single word at address 0.
        d0 = done_cnt; w0 = we_cnt;
        start_load(10'd0, 11'd1);
        send_word(32'h0000_0013, 0);
        finish_load(d0, 32'h0000_0013);
        check("t1_write_count", we_cnt - w0, 32'h1);

        // Two words ending exactly at the top of memory, gappy upstream.
        d0 = done_cnt; w0 = we_cnt;
        start_load(10'd1022, 11'd2);
        send_word(32'hDEAD_BEEF, 3);
        send_word(32'h0000_0013, 3);
        finish_load(d0, 32'hDEAD_BEFC);
        check("t2_write_count", we_cnt - w0, 32'h2);

        // Illegal starts.
        reject(10'd1020, 11'd5);
        reject(10'd1020, 11'd0);
        reject(10'd0, 11'd1025);
        reject(10'd1023, 11'd2);

        // Abort after two bytes of the third word of a four-word load.
        d0 = done_cnt; w0 = we_cnt;
        start_load(10'd100, 11'd4);
        send_word(32'h1122_3344, 0);
        send_word(32'h5566_7788, 1);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        e0 = err_cnt;
        abort = 1'b1;
        @(negedge clk);
        check("abort_load_we", {31'b0, mem_we}, 32'h0);
        check("abort_load_ready", {31'b0, byte_ready}, 32'h0);
        tick();
        abort = 1'b0;
        byte_valid = 1'b1;
        @(negedge clk);
        check("abort_err", {31'b0, err}, 32'h1);
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_checksum_kept", checksum, 32'hDEAD_BEFC);
        repeat (8) tick();
        byte_valid = 1'b0;
        check("abort_write_count", we_cnt - w0, 32'h2);
        check("abort_err_count", err_cnt - e0, 32'h1);
        check("abort_no_done", done_cnt - d0, 32'h0);

        // Abort while the word is being written.
        w0 = we_cnt; e0 = err_cnt;
        start_load(10'd5, 11'd1);
        send_byte(8'h0D, 0);
        send_byte(8'hF0, 0);
        send_byte(8'hFE, 0);
        send_byte(8'hCA, 0);
        abort = 1'b1;
        @(negedge clk);
        check("abort_write_we", {31'b0, mem_we}, 32'h0);
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_write_err", {31'b0, err}, 32'h1);
        check("abort_write_busy", {31'b0, busy}, 32'h0);
        tick();
        check("abort_write_count", we_cnt - w0, 32'h0);
        check("abort_write_err_count", err_cnt - e0, 32'h1);

        // Asynchronous reset in the write cycle.
        d0 = done_cnt; e0 = err_cnt;
        start_load(10'd10, 11'd2);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        check("pre_reset_we", {31'b0, mem_we}, 32'h1);
        rst = 1'b1;
        #1;
        check("async_reset_we", {31'b0, mem_we}, 32'h0);
        check("async_reset_busy", {31'b0, busy}, 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        check("reset_no_done", done_cnt - d0, 32'h0);
        check("reset_no_err", err_cnt - e0, 32'h0);
        d0 = done_cnt;
        start_load(10'd0, 11'd1);
        send_word(32'h0000_0013, 0);
        finish_load(d0, 32'h0000_0013);

        // Full-memory load.
        d0 = done_cnt; w0 = we_cnt;
        start_load(10'd0, 11'd1024);
        for (int i = 0; i < 1024; i++) begin
            v = 32'(i + 1);
            send_word((v << 20) | v, 0);
        end
        finish_load(d0, 32'h4000_0400);
        check("full_write_count", we_cnt - w0, 32'd1024);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
